rr_select8: RTL and testbench

Round-robin source selector that drives the 3-bit select of the 8-lane, 8-bit `Mux8x8` datapath and registers the byte it produces. Eight upstream channels raise requests. The block picks one per transfer with a rotating-priority pointer and presents its index on `S`. It then captures the mux output into a one-entry output register with a valid/ready handshake towards the downstream consumer. Full throughput is one byte per cycle.

---
 rtl/rr_select8_if.sv | 31 +++
 rtl/rr_select8.sv | 82 ++++++++
 tb/tb_rr_select8.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rr_select8_if.sv
// Request/select/output bundle between the round-robin selector, the Mux8x8 datapath and the
// downstream consumer. The master modport is the selector side.
interface rr_select8_if;
  logic [7:0] REQ;
  logic [7:0] MUX_O;
  logic [2:0] S;
  logic [7:0] ACK;
  logic       O_VALID;
  logic [7:0] O_DATA;
  logic       O_READY;

  modport master (
    input  REQ,
    input  MUX_O,
    input  O_READY,
    output S,
    output ACK,
    output O_VALID,
    output O_DATA
  );

  modport slave (
    output REQ,
    output MUX_O,
    output O_READY,
    input  S,
    input  ACK,
    input  O_VALID,
    input  O_DATA
  );
endinterface

// File: rtl/rr_select8.sv
// Round-robin selector for an 8-lane byte mux with a one-entry valid/ready output register.
// The rotating pointer names the highest-priority lane for the next grant; the winning lane
// index drives the mux select and the returned byte is captured on the same edge as the ACK.
module rr_select8 (
  input logic      CLK,
  input logic      RESET,
  rr_select8_if.master bus
);

  logic [2:0] ptr_q, ptr_d;
  logic       o_valid_q, o_valid_d;
  logic [7:0] o_data_q, o_data_d;

  logic       hit;
  logic       found;
  logic [2:0] win;
  logic [2:0] idx;
  logic       load;

  // Circular priority search starting at the pointer.
  always_comb begin
    hit   = |bus.REQ;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && bus.REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Capture when a lane is requesting and the register is empty or draining; never in reset.
  always_comb begin
    load = hit & (~o_valid_q | bus.O_READY) & ~RESET;
  end

  // Select and acknowledge outputs; select parks on the pointer when nobody requests.
  always_comb begin
    bus.S   = 3'd0;
    bus.ACK = 8'h00;
    if (!RESET) begin
      bus.S = hit ? win : ptr_q;
    end
    if (load) begin
      bus.ACK = 8'h01 << win;
    end
  end

  // Next-state for pointer and output register.
  always_comb begin
    ptr_d     = ptr_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    if (load) begin
      o_data_d  = bus.MUX_O;
      o_valid_d = 1'b1;
      ptr_d     = win + 3'd1;
    end else if (o_valid_q && bus.O_READY) begin
      o_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q     <= 3'd0;
      o_valid_q <= 1'b0;
      o_data_q  <= 8'h00;
    end else begin
      ptr_q     <= ptr_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign bus.O_VALID = o_valid_q;
  assign bus.O_DATA  = o_data_q;

endmodule

// File: tb/tb_rr_select8.sv
// Randomized and directed checks of rr_select8 against a behavioural round-robin model.
module tb_rr_select8;

  logic clk = 1'b0;
  logic RESET;
  logic [7:0] lane_data [8];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;

  logic [2:0] last_s;
  logic [7:0] last_ack;

  rr_select8_if bus ();

  rr_select8 u_dut (
    .CLK   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural Mux8x8
  always_comb bus.MUX_O = lane_data[bus.S];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int winner(input int p, input logic [7:0] r);
    for (int i = 0; i < 8; i++) begin
      if (r[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check mid-cycle, step the model at the edge.
  task automatic run_cycle(input logic rst, input logic [7:0] req, input logic rdy);
    int  w;
    bit  load;
    logic [2:0] e_s;
    logic [7:0] e_ack;
    RESET       = rst;
    bus.REQ     = req;
    bus.O_READY = rdy;
    @(negedge clk);
    w     = winner(m_ptr, req);
    load  = !rst && (w >= 0) && (!m_valid || rdy);
    e_s   = rst ? 3'd0 : ((w >= 0) ? 3'(w) : 3'(m_ptr));
    e_ack = load ? (8'h01 << w) : 8'h00;
    last_s   = bus.S;
    last_ack = bus.ACK;
    check_eq("s", 32'(bus.S), 32'(e_s));
    check_eq("ack", 32'(bus.ACK), 32'(e_ack));
    check_eq("o_valid", 32'(bus.O_VALID), 32'(m_valid));
    check_eq("o_data", 32'(bus.O_DATA), 32'(m_data));
    if (rst) begin
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else if (load) begin
      m_data  = lane_data[w];
      m_valid = 1'b1;
      m_ptr   = (w + 1) % 8;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) lane_data[k] = 8'h10 + 8'(k);
    RESET       = 1'b1;
    bus.REQ     = 8'hFF;
    bus.O_READY = 1'b1;
    // First edge only initialises the DUT; model starts from the reset state afterwards.
    @(posedge clk);
    #1;
    m_ptr = 0; m_valid = 1'b0; m_data = 8'h00;

    // Reset with all requests high
    run_cycle(1'b1, 8'hFF, 1'b1);
    check_eq("rst_ack", 32'(last_ack), 32'h0);
    check_eq("rst_s", 32'(last_s), 32'h0);
    run_cycle(1'b0, 8'h00, 1'b1);
    check_eq("rst_ptr", 32'(last_s), 32'h0);

    // Single request on lane 5
    lane_data[5] = 8'hA5;
    run_cycle(1'b0, 8'h20, 1'b1);
    check_eq("single_s", 32'(last_s), 32'd5);
    check_eq("single_ack", 32'(last_ack), 32'h20);
    check_eq("single_valid", 32'(bus.O_VALID), 32'h1);
    check_eq("single_data", 32'(bus.O_DATA), 32'hA5);
    run_cycle(1'b0, 8'h00, 1'b1);
    check_eq("single_ptr", 32'(last_s), 32'd6);

    // Rotation skip from pointer 6
    run_cycle(1'b0, 8'h05, 1'b1);
    check_eq("skip_g0", 32'(last_ack), 32'h01);
    run_cycle(1'b0, 8'h04, 1'b1);
    check_eq("skip_g2", 32'(last_ack), 32'h04);
    run_cycle(1'b0, 8'h00, 1'b1);
    check_eq("skip_ptr", 32'(last_s), 32'd3);

    // Full contention from pointer 0
    lane_data[5] = 8'h15;
    run_cycle(1'b1, 8'h00, 1'b1);
    for (int n = 0; n < 10; n++) begin
      run_cycle(1'b0, 8'hFF, 1'b1);
      check_eq("full_valid", 32'(bus.O_VALID), 32'h1);
      check_eq("full_data", 32'(bus.O_DATA), 32'(8'h10 + 8'(n % 8)));
    end

    // Backpressure holding 3C
    lane_data[3] = 8'h3C;
    run_cycle(1'b0, 8'h08, 1'b1);
    for (int n = 0; n < 4; n++) begin
      run_cycle(1'b0, 8'h01, 1'b0);
      check_eq("bp_ack", 32'(last_ack), 32'h0);
      check_eq("bp_data", 32'(bus.O_DATA), 32'h3C);
    end
    run_cycle(1'b0, 8'h01, 1'b1);
    check_eq("bp_release_ack", 32'(last_ack), 32'h01);
    check_eq("bp_release_data", 32'(bus.O_DATA), 32'h10);

    // Mid-transfer reset
    run_cycle(1'b0, 8'h02, 1'b0);
    run_cycle(1'b1, 8'h02, 1'b0);
    check_eq("midrst_ack", 32'(last_ack), 32'h0);
    check_eq("midrst_valid", 32'(bus.O_VALID), 32'h0);
    run_cycle(1'b0, 8'h00, 1'b0);
    check_eq("midrst_ptr", 32'(last_s), 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] req;
      for (int k = 0; k < 8; k++) lane_data[k] = 8'($urandom);
      req = 8'($urandom) & 8'($urandom);
      run_cycle(($urandom_range(0, 49) == 0), req, ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
